// File: rtl/reg_pipe.sv
// Programmable-latency delay line: DEPTH-stage register chain with per-stage valid,
// global stall, synchronous flush, tap read-out and an occupancy counter.
module reg_pipe #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int TW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] D,
    input  logic             DValid,
    input  logic             En,
    input  logic             Flush,
    input  logic [TW-1:0]    TapSel,
    output logic [WIDTH-1:0] Q,
    output logic             QValid,
    output logic [WIDTH-1:0] TapQ,
    output logic             TapValid,
    output logic [CW-1:0]    Count
);

    logic [WIDTH-1:0] data_r [DEPTH];
    logic [DEPTH-1:0] valid_r;
    logic [CW-1:0]    count_r;

    // Stage 0 is masked with DValid so every invalid slot carries zero data.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
            valid_r <= '0;
            count_r <= '0;
        end else if (Flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_r[i] <= '0;
            end
            valid_r <= '0;
            count_r <= '0;
        end else if (En) begin
            data_r[0]  <= DValid ? D : '0;
            valid_r[0] <= DValid;
            for (int i = 1; i < DEPTH; i++) begin
                data_r[i]  <= data_r[i-1];
                valid_r[i] <= valid_r[i-1];
            end
            count_r <= count_r + CW'(DValid) - CW'(valid_r[DEPTH-1]);
        end
    end

    // Selecting by comparison keeps out-of-range TapSel values at zero.
    always_comb begin
        TapQ     = '0;
        TapValid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (TapSel == TW'(i)) begin
                TapQ     = data_r[i];
                TapValid = valid_r[i];
            end
        end
    end

    assign Q      = data_r[DEPTH-1];
    assign QValid = valid_r[DEPTH-1];
    assign Count  = count_r;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed bench for reg_pipe (DEPTH=4 and DEPTH=3 instances) with a queue
// scoreboard on the DEPTH=4 output.
module tb_reg_pipe;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] D;
    logic        DValid, En, Flush;
    logic [1:0]  TapSel, tap_sel3;

    logic [15:0] Q, TapQ, q3, tap_q3;
    logic        QValid, TapValid, q_valid3, tap_valid3;
    logic [2:0]  Count;
    logic [1:0]  count3;

    int          applied     = 0;
    int          miscompares = 0;
    logic [15:0] sb [$];

    always #5 Clk = ~Clk;

    reg_pipe #(.WIDTH(16), .DEPTH(4)) dut (
        .Clk(Clk), .Rst(Rst), .D(D), .DValid(DValid), .En(En), .Flush(Flush),
        .TapSel(TapSel), .Q(Q), .QValid(QValid), .TapQ(TapQ),
        .TapValid(TapValid), .Count(Count)
    );

    reg_pipe #(.WIDTH(16), .DEPTH(3)) dut3 (
        .Clk(Clk), .Rst(Rst), .D(D), .DValid(DValid), .En(En), .Flush(Flush),
        .TapSel(tap_sel3), .Q(q3), .QValid(q_valid3), .TapQ(tap_q3),
        .TapValid(tap_valid3), .Count(count3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        applied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic dv, input logic en, input logic fl);
        D      = d;
        DValid = dv;
        En     = en;
        Flush  = fl;
    endtask

    // Inputs are captured before the edge; expected items enter the scoreboard
    // on enabled edges and are retired whenever the DEPTH=4 pipe shows QValid.
    task automatic clockEdge();
        logic [15:0] d_at;
        logic        dv_at, en_at, fl_at;
        logic [15:0] exp;
        d_at  = D;
        dv_at = DValid;
        en_at = En;
        fl_at = Flush;
        @(posedge Clk);
        #1;
        if (fl_at) begin
            sb.delete();
        end else if (en_at) begin
            if (dv_at) sb.push_back(d_at);
            if (QValid) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_spurious_qvalid", 32'(QValid), 32'd0);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("sb_q", 32'(Q), 32'(exp));
                end
            end
        end
    endtask

    initial begin
        Rst      = 1'b1;
        TapSel   = 2'd0;
        tap_sel3 = 2'd0;
        applyStimulus(16'h5A5A, 1'b1, 1'b1, 1'b0);
        #3;
        checkOutput("rst_q",        32'(Q),        32'd0);
        checkOutput("rst_qvalid",   32'(QValid),   32'd0);
        checkOutput("rst_count",    32'(Count),    32'd0);
        checkOutput("rst_tapq",     32'(TapQ),     32'd0);
        checkOutput("rst_tapvalid", 32'(TapValid), 32'd0);
        #4;
        Rst = 1'b0;

        // Single item latency
        applyStimulus(16'hBEEF, 1'b1, 1'b1, 1'b0);
        clockEdge();
        checkOutput("lat_count_e1", 32'(Count), 32'd1);
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0);
        for (int i = 2; i <= 3; i++) begin
            clockEdge();
            checkOutput("lat_qvalid_early", 32'(QValid), 32'd0);
            checkOutput("lat_count_mid",    32'(Count),  32'd1);
        end
        clockEdge();
        checkOutput("lat_qvalid_e4", 32'(QValid), 32'd1);
        checkOutput("lat_q_e4",      32'(Q),      32'hBEEF);
        checkOutput("lat_count_e4",  32'(Count),  32'd1);
        clockEdge();
        checkOutput("lat_qvalid_e5", 32'(QValid), 32'd0);
        checkOutput("lat_q_e5",      32'(Q),      32'd0);
        checkOutput("lat_count_e5",  32'(Count),  32'd0);

        // Back-to-back stream with tap read-out
        TapSel = 2'd1;
        applyStimulus(16'hBEEF, 1'b1, 1'b1, 1'b0); clockEdge();
        applyStimulus(16'hEB16, 1'b1, 1'b1, 1'b0); clockEdge();
        applyStimulus(16'hABCB, 1'b1, 1'b1, 1'b0); clockEdge();
        applyStimulus(16'h1234, 1'b1, 1'b1, 1'b0); clockEdge();
        checkOutput("str_q",        32'(Q),        32'hBEEF);
        checkOutput("str_tapq1",    32'(TapQ),     32'hABCB);
        checkOutput("str_tapvalid", 32'(TapValid), 32'd1);
        checkOutput("str_count4",   32'(Count),    32'd4);
        TapSel = 2'd3;
        #1;
        checkOutput("str_tapq3_eq_q", 32'(TapQ), 32'hBEEF);
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0); clockEdge();
        checkOutput("str_q5",      32'(Q),     32'hEB16);
        checkOutput("str_count5",  32'(Count), 32'd3);
        for (int i = 0; i < 3; i++) clockEdge();
        checkOutput("str_drained", 32'(Count), 32'd0);

        // Stall holds every stage and blocks new data
        applyStimulus(16'hBEEF, 1'b1, 1'b1, 1'b0); clockEdge();
        applyStimulus(16'hEB16, 1'b1, 1'b1, 1'b0); clockEdge();
        applyStimulus(16'hFFFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            clockEdge();
            checkOutput("stall_count",  32'(Count),  32'd2);
            checkOutput("stall_qvalid", 32'(QValid), 32'd0);
        end
        TapSel = 2'd0;
        #1;
        checkOutput("stall_tap0", 32'(TapQ), 32'hEB16);
        TapSel = 2'd1;
        #1;
        checkOutput("stall_tap1", 32'(TapQ), 32'hBEEF);
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0);
        clockEdge();
        checkOutput("stall_resume_qvalid", 32'(QValid), 32'd0);
        clockEdge();
        checkOutput("stall_lat7_qvalid", 32'(QValid), 32'd1);
        checkOutput("stall_lat7_q",      32'(Q),      32'hBEEF);
        clockEdge();
        checkOutput("stall_q_next", 32'(Q), 32'hEB16);
        clockEdge();
        checkOutput("stall_empty", 32'(Count), 32'd0);

        // Flush beats En and discards the incoming item
        applyStimulus(16'h1111, 1'b1, 1'b1, 1'b0); clockEdge();
        applyStimulus(16'h2222, 1'b1, 1'b1, 1'b0); clockEdge();
        applyStimulus(16'h3333, 1'b1, 1'b1, 1'b0); clockEdge();
        checkOutput("fl_pre_count", 32'(Count), 32'd3);
        applyStimulus(16'hABCB, 1'b1, 1'b1, 1'b1); clockEdge();
        checkOutput("fl_count",  32'(Count),  32'd0);
        checkOutput("fl_qvalid", 32'(QValid), 32'd0);
        checkOutput("fl_q",      32'(Q),      32'd0);
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            clockEdge();
            checkOutput("fl_after_qvalid", 32'(QValid), 32'd0);
            checkOutput("fl_after_q",      32'(Q),      32'd0);
        end

        // Tap bounds on the DEPTH=3 instance
        applyStimulus(16'hAAAA, 1'b1, 1'b1, 1'b0); clockEdge();
        applyStimulus(16'hBBBB, 1'b1, 1'b1, 1'b0); clockEdge();
        applyStimulus(16'hCCCC, 1'b1, 1'b1, 1'b0); clockEdge();
        tap_sel3 = 2'd3;
        #1;
        checkOutput("d3_tap3_q",     32'(tap_q3),     32'd0);
        checkOutput("d3_tap3_valid", 32'(tap_valid3), 32'd0);
        tap_sel3 = 2'd2;
        #1;
        checkOutput("d3_tap2_q",     32'(tap_q3),     32'hAAAA);
        checkOutput("d3_tap2_valid", 32'(tap_valid3), 32'd1);
        checkOutput("d3_q",          32'(q3),         32'hAAAA);
        checkOutput("d3_count",      32'(count3),     32'd3);
        checkOutput("d4_count3",     32'(Count),      32'd3);
        applyStimulus(16'hDDDD, 1'b1, 1'b1, 1'b0); clockEdge();
        checkOutput("d4_full_count",  32'(Count),  32'd4);
        checkOutput("d4_full_qvalid", 32'(QValid), 32'd1);
        checkOutput("d3_q_next",      32'(q3),     32'hBBBB);

        // Asynchronous reset mid-cycle with items in flight
        #2;
        D      = 16'hDEAD;
        DValid = 1'b1;
        Rst    = 1'b1;
        #1;
        checkOutput("arst_q",       32'(Q),        32'd0);
        checkOutput("arst_qvalid",  32'(QValid),   32'd0);
        checkOutput("arst_count",   32'(Count),    32'd0);
        checkOutput("arst_d3_q",    32'(q3),       32'd0);
        checkOutput("arst_d3_cnt",  32'(count3),   32'd0);
        #19;
        Rst = 1'b0;
        sb.delete();
        checkOutput("arst_hold_count", 32'(Count),  32'd0);
        checkOutput("arst_hold_qv",    32'(QValid), 32'd0);

        // Recovery after reset
        applyStimulus(16'hBEEF, 1'b1, 1'b1, 1'b0); clockEdge();
        applyStimulus(16'h0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) clockEdge();
        checkOutput("rec_qvalid", 32'(QValid), 32'd1);
        checkOutput("rec_count",  32'(Count),  32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_pipe.md
Name: reg_pipe

Overview:
- Parametrised successor to the single-stage WIDTH register: a DEPTH-stage pipelined register chain with a per-stage valid bit, global stall (En), synchronous flush, a selectable tap read-out and an occupancy counter.
- Used as a programmable-latency delay line between datapath blocks. It aligns operands or results that arrive with different latencies.

Parameters:
- WIDTH, 16, data width in bits per stage (>=1).
- DEPTH, 4, number of pipeline stages = latency in enabled cycles (>=1).
- CW, $clog2(DEPTH+1), derived (localparam): width of Count; not to be overridden.
- TW, $clog2(DEPTH) (minimum 1), derived (localparam): width of TapSel.

Ports:
- Clk  input  1  rising-edge clock; single clock domain.
- Rst  input  1  asynchronous reset, active-high.
- D  input  WIDTH  data into stage 0.
- DValid  input  1  D carries a valid item this cycle.
- En  input  1  advance enable; 0 = stall, all stages hold.
- Flush  input  1  synchronous clear of the whole pipe; priority over En.
- TapSel  input  TW  stage index for the tap read-out.
- Q  output  WIDTH  data of last stage (stage DEPTH-1), registered.
- QValid  output  1  valid bit of last stage.
- TapQ  output  WIDTH  data of stage TapSel (combinational mux of registers).
- TapValid  output  1  valid bit of stage TapSel.
- Count  output  CW  number of stages currently holding valid items, registered.

Behaviour:
- Reset (Rst=1, asynchronous, no clock needed): all stage data=0, all valid=0, Count=0; hence Q=0, QValid=0, TapQ=0, TapValid=0. Effect is immediate on Rst assertion, including mid-operation; in-flight items are lost. The first capture occurs on the first rising Clk edge with Rst low.
- Per rising edge, priority order Flush > En > hold:
  - Flush=1: every stage data<=0, valid<=0, Count<=0. D/DValid that cycle are discarded, regardless of En.
  - Flush=0, En=1: stage0.data<=(DValid ? D : 0), stage0.valid<=DValid; stage i<=stage i-1 for i=1..DEPTH-1. The last stage's old contents leave the pipe.
  - Flush=0, En=0: all stages and Count hold; D ignored.
- Latency: an item entering with DValid=1 on edge k appears on Q/QValid after DEPTH enabled edges (edge k counts as the first). Stalled cycles add latency one-for-one. No bubbles are collapsed; the pipe is a strict shift register.
- Invalid slots always carry data 0. Q=0 whenever QValid=0.
- Count on an enabled edge = Count + DValid - (old last-stage valid). Count always equals the popcount of the valid bits. Range 0..DEPTH; it cannot wrap because at most one item enters and the last stage always exits on an enabled edge.
- Simultaneous input and output on one enabled edge with DValid=1 and last stage valid: Count is unchanged.
- Tap: TapQ/TapValid reflect stage TapSel in the same cycle (no added latency); TapSel=DEPTH-1 mirrors Q/QValid. TapSel>=DEPTH (possible when DEPTH is not a power of 2) gives TapQ=0, TapValid=0.
- DEPTH=1: single register with valid; Count in {0,1}; TapSel only meaningful at 0.
- No X propagation from D when DValid=0 (masked to 0).

Test Plan:
- Reset: WIDTH=16, DEPTH=4. Assert Rst mid-clock for 20 ns with garbage on D -> Q=0, QValid=0, Count=0 immediately on Rst rise, not at the next edge.
- Latency: En=1; D=16'hBEEF, DValid=1 for one edge, then DValid=0 -> QValid=1 and Q=BEEF exactly 4 edges later for one cycle. Count goes 1,1,1,1 then 0.
- Stream + tap: BEEF, EB16, ABCB, 1234 on consecutive edges, TapSel=1 -> after edge 4 Q=BEEF, TapQ=ABCB, Count=4. A fifth edge with DValid=0 gives Q=EB16, Count=3.
- Stall: fill with BEEF, EB16; hold En=0 for 3 edges with DValid=1, D=FFFF -> no stage changes, Count holds at 2, FFFF never enters. Restoring En resumes with total latency 4+3 for BEEF.
- Flush priority: pipe holds 3 items; Flush=1, En=1, DValid=1, D=ABCB on one edge -> all valid=0, Q=0, Count=0. ABCB never appears on Q.
- Tap bounds: DEPTH=3, TapSel=3 with a full pipe -> TapQ=0, TapValid=0. TapSel=2 equals Q.
